// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles every signal of the shared memory port arbiter:
//   i_*  : instruction-fetch requester (request, address, grant, response)
//   d_*  : load/store requester (request, write enable, address, write data,
//          byte mask, grant, response)
//   m_*  : unified memory port (registered request fields, ack, read data)
//   err  : pulses with the rvalid of an access that hit the latency watchdog
// Modports:
//   master : the arbiter's view (drives grants, responses and the memory request)
//   slave  : the environment's view (CPU requesters and the memory)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  // Fetch side
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  // Load/store side
  logic              d_req;
  logic              d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [MASK_W-1:0] d_wmask;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  // Memory side
  logic              m_req;
  logic              m_wen;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [MASK_W-1:0] m_wmask;
  logic              m_ack;
  logic [DATA_W-1:0] m_rdata;

  logic              err;

  modport master (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_wen, d_addr, d_wdata, d_wmask,
    output d_gnt, d_rvalid, d_rdata,
    output m_req, m_wen, m_addr, m_wdata, m_wmask,
    input  m_ack, m_rdata,
    output err
  );

  modport slave (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_wen, d_addr, d_wdata, d_wmask,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_req, m_wen, m_addr, m_wdata, m_wmask,
    output m_ack, m_rdata,
    input  err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between the instruction-fetch path and the load/store
// path. One access is in flight at a time; the granted request is copied into
// registered m_* outputs and the response is returned to its owner as a
// one-cycle rvalid pulse. A 16-bit wait counter forces completion with the
// pattern 0xDEADBEEF and an err pulse if the memory never acknowledges.
//
// Parameters:
//   ADDR_W  : address width of both requesters and the memory port
//   DATA_W  : data width (byte mask is DATA_W/8)
//   TIMEOUT : memory wait cycles before forced completion (1..65535)
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : mem_port_arbiter_if.master (fetch, load/store and memory signals)
//
// Configuration macro ARB_ROUND_ROBIN_EN:
//   defined   : on contention the requester not served last wins (data wins
//               the first contest)
//   undefined : data always wins over fetch
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);
  localparam int MASK_W = DATA_W / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [15:0]       TIMEOUT_CNT  = 16'(TIMEOUT);
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEADBEEF);

  logic [1:0]        r_state;
  logic              r_owner_d;   // 1: in-flight access belongs to load/store
  logic              r_err;
  logic [15:0]       r_wait_cnt;
  logic              r_m_req;
  logic              r_m_wen;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;
  logic [MASK_W-1:0] r_m_wmask;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_grant_win;
  logic w_data_pref;
  logic w_d_gnt;
  logic w_i_gnt;

  // ---------------------------------------------------------------------------
  // Grant logic: grants only when no access is in flight (IDLE) or when the
  // previous one is being returned (RESP), which gives back-to-back issue.
  // ---------------------------------------------------------------------------
  assign w_grant_win = (r_state == ST_IDLE) || (r_state == ST_RESP);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_data;  // 1: load/store was granted last; resets to "fetch"

  assign w_data_pref = !r_last_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_data <= 1'b0;
    end else if (w_d_gnt || w_i_gnt) begin
      r_last_data <= w_d_gnt;
    end
  end
`else
  // Load/store belongs to an older instruction, so it always goes first.
  assign w_data_pref = 1'b1;
`endif

  assign w_d_gnt = w_grant_win && bus.d_req && (!bus.i_req || w_data_pref);
  assign w_i_gnt = w_grant_win && bus.i_req && !w_d_gnt;

  // ---------------------------------------------------------------------------
  // Transaction FSM and registered memory request
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_owner_d  <= 1'b0;
      r_err      <= 1'b0;
      r_wait_cnt <= '0;
      r_m_req    <= 1'b0;
      r_m_wen    <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_m_wmask  <= '0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      case (r_state)
        ST_BUSY: begin
          // An ack in the very cycle the limit is reached still wins.
          if (bus.m_ack) begin
            if (r_owner_d) begin
              r_d_rdata <= r_m_wen ? '0 : bus.m_rdata;
            end else begin
              r_i_rdata <= bus.m_rdata;
            end
            r_err   <= 1'b0;
            r_m_req <= 1'b0;
            r_state <= ST_RESP;
          end else if (r_wait_cnt == TIMEOUT_CNT) begin
            if (r_owner_d) begin
              r_d_rdata <= TIMEOUT_DATA;
            end else begin
              r_i_rdata <= TIMEOUT_DATA;
            end
            r_err   <= 1'b1;
            r_m_req <= 1'b0;
            r_state <= ST_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        default: begin
          // IDLE, RESP (and any unused encoding) fall back to IDLE unless a
          // grant below starts a new access in this same cycle.
          r_state <= ST_IDLE;
          r_err   <= 1'b0;
        end
      endcase

      if (w_d_gnt || w_i_gnt) begin
        r_state    <= ST_BUSY;
        r_owner_d  <= w_d_gnt;
        r_err      <= 1'b0;
        r_wait_cnt <= '0;
        r_m_req    <= 1'b1;
        // Fetches are always reads with no byte enables.
        r_m_wen    <= w_d_gnt && bus.d_wen;
        r_m_addr   <= w_d_gnt ? bus.d_addr : bus.i_addr;
        r_m_wdata  <= w_d_gnt ? bus.d_wdata : '0;
        r_m_wmask  <= w_d_gnt ? bus.d_wmask : '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.i_gnt    = w_i_gnt;
  assign bus.d_gnt    = w_d_gnt;
  assign bus.i_rvalid = (r_state == ST_RESP) && !r_owner_d;
  assign bus.d_rvalid = (r_state == ST_RESP) &&  r_owner_d;
  assign bus.err      = (r_state == ST_RESP) &&  r_err;
  assign bus.i_rdata  = r_i_rdata;
  assign bus.d_rdata  = r_d_rdata;
  assign bus.m_req    = r_m_req;
  assign bus.m_wen    = r_m_wen;
  assign bus.m_addr   = r_m_addr;
  assign bus.m_wdata  = r_m_wdata;
  assign bus.m_wmask  = r_m_wmask;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter with TIMEOUT=4. A behavioural memory
// acks after a programmable number of wait cycles (or never). Expected
// responses are queued per requester when a request is driven and compared
// when the matching rvalid appears. Grant order, request field copies, reset
// behaviour and response latency are checked as well.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t q_i[$];
  exp_t q_d[$];
  bit   gnt_log[$];   // 1 = data grant, 0 = fetch grant

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  int g_cyc_i   = 0;
  int g_cyc_d   = 0;
  int dual_cnt  = 0;
  int ack_delay = 0;
  bit no_ack    = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] addr);
    if (addr == 32'h8000_0000) return 32'h0000_0413;
    return {addr[15:0], addr[31:16]} ^ 32'h0F0F_0F0F;
  endfunction

  // Cycle counter: sampled on negedges, so no race with the increment.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural memory: ack after ack_delay wait cycles of m_req.
  initial begin
    int mcnt;
    mcnt = 0;
    bus.m_ack   = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.m_req && !no_ack && mcnt == ack_delay) begin
        bus.m_ack   = 1'b1;
        bus.m_rdata = mem_fn(bus.m_addr);
      end else begin
        bus.m_ack   = 1'b0;
        bus.m_rdata = 32'h5A5A_5A5A;
      end
      mcnt = bus.m_req ? mcnt + 1 : 0;
    end
  end

  // Response monitor / scoreboard compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.i_rvalid) begin
        if (q_i.size() == 0) begin
          check("i_rvalid_unexpected", 1, 0);
        end else begin
          e = q_i.pop_front();
          check("i_rdata", bus.i_rdata, e.data);
          check("i_err", bus.err, e.err);
          check("i_latency", cyc - g_cyc_i, e.lat);
          $display("fetch resp cyc=%0d data=0x%08h err=%0b lat=%0d", cyc, bus.i_rdata, bus.err, cyc - g_cyc_i);
        end
      end
      if (bus.d_rvalid) begin
        if (q_d.size() == 0) begin
          check("d_rvalid_unexpected", 1, 0);
        end else begin
          e = q_d.pop_front();
          check("d_rdata", bus.d_rdata, e.data);
          check("d_err", bus.err, e.err);
          check("d_latency", cyc - g_cyc_d, e.lat);
          $display("data  resp cyc=%0d data=0x%08h err=%0b lat=%0d", cyc, bus.d_rdata, bus.err, cyc - g_cyc_d);
        end
      end
      if (bus.err && !bus.i_rvalid && !bus.d_rvalid) check("err_stray", 1, 0);
      // Grants after responses so a same-cycle regrant does not skew latency.
      if (bus.i_gnt && bus.d_gnt) dual_cnt++;
      if (bus.d_gnt) begin
        g_cyc_d = cyc;
        gnt_log.push_back(1'b1);
      end else if (bus.i_gnt) begin
        g_cyc_i = cyc;
        gnt_log.push_back(1'b0);
      end
    end
  end

  // One request: queue expectation, hold req until granted, check m_* copy.
  task automatic txn(input bit is_d, input bit wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wmask);
    exp_t  e;
    bit    got;
    string pfx;
    if (is_d) pfx = "d"; else pfx = "i";
    e.err  = no_ack;
    e.lat  = no_ack ? TMO + 2 : ack_delay + 2;
    e.data = no_ack ? 32'hDEAD_BEEF : ((is_d && wen) ? 32'h0 : mem_fn(addr));
    if (is_d) begin
      q_d.push_back(e);
      bus.d_req = 1'b1; bus.d_wen = wen; bus.d_addr = addr;
      bus.d_wdata = wdata; bus.d_wmask = wmask;
    end else begin
      q_i.push_back(e);
      bus.i_req = 1'b1; bus.i_addr = addr;
    end
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = is_d ? bus.d_gnt : bus.i_gnt;
    end
    if (!got) check({pfx, "_gnt_wait"}, 0, 1);
    @(posedge clk);
    #1;
    if (is_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
    if (got) begin
      check({pfx, "_m_req"}, bus.m_req, 1);
      check({pfx, "_m_addr"}, bus.m_addr, addr);
      check({pfx, "_m_wen"}, bus.m_wen, is_d && wen);
      check({pfx, "_m_wmask"}, bus.m_wmask, is_d ? wmask : 4'h0);
      if (is_d && wen) check({pfx, "_m_wdata"}, bus.m_wdata, wdata);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((q_i.size() != 0 || q_d.size() != 0) && k < 100) begin
      @(posedge clk);
      k++;
    end
    check("drain", q_i.size() + q_d.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_req"}, bus.m_req, 0);
    check({tag, "_m_addr"}, bus.m_addr, 0);
    check({tag, "_m_wdata"}, bus.m_wdata, 0);
    check({tag, "_i_rdata"}, bus.i_rdata, 0);
    check({tag, "_d_rdata"}, bus.d_rdata, 0);
    check({tag, "_flags"}, {bus.m_wen, bus.m_wmask, bus.err, bus.i_rvalid, bus.d_rvalid,
                           bus.i_gnt, bus.d_gnt}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    bit exp_order[4];
    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_wen = 1'b0; bus.d_addr = '0;
    bus.d_wdata = '0; bus.d_wmask = '0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single fetch, memory acks one cycle after m_req -> rvalid at cycle 3.
    ack_delay = 1;
    txn(1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
    wait_idle();

    // Zero-wait store -> d_rvalid at cycle 2 with d_rdata=0.
    ack_delay = 0;
    txn(1'b1, 1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF);
    wait_idle();
    check("i_rdata_hold", bus.i_rdata, 32'h0000_0413);

    // Ack in the very cycle the wait counter reaches TIMEOUT: ack wins.
    ack_delay = TMO;
    txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
    wait_idle();

    // Contention: both requesters hold two requests each.
    ack_delay = 0;
    gnt_log.delete();
    dual_cnt = 0;
    fork
      begin
        txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
        txn(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0);
      end
      begin
        txn(1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
        txn(1'b0, 1'b0, 32'h0000_0204, 32'h0, 4'h0);
      end
    join
    wait_idle();
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b0, 1'b0};
`endif
    check("grant_count", gnt_log.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < gnt_log.size()) check($sformatf("grant_order%0d", k), gnt_log[k], exp_order[k]);
    end
    check("dual_grant_cycles", dual_cnt, 0);
    $display("contention grants %0d cycles with two grants %0d", gnt_log.size(), dual_cnt);

    // Timeout: no ack -> DEADBEEF with err at TIMEOUT+2.
    no_ack = 1'b1;
    txn(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
    wait_idle();
    no_ack = 1'b0;
    check("d_rdata_tmo_hold", bus.d_rdata, 32'hDEAD_BEEF);

    // Back in IDLE: a new fetch is granted in the cycle it is raised.
    ack_delay = 0;
    c0 = cyc;
    txn(1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
    check("idle_after_tmo_gnt", g_cyc_i - c0, 0);
    wait_idle();

    // Reset two cycles after a grant, while the access is still waiting.
    no_ack = 1'b1;
    txn(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_d.delete();
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    no_ack = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Normal service resumes.
    ack_delay = 1;
    txn(1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
    wait_idle();
    ack_delay = 0;
    txn(1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory port between the CPU instruction-fetch path (IRAM side) and its load/store path (DRAM side). The block sits between the CPU and one unified memory. It accepts at most one transaction at a time and drives the memory with registered request signals. It then returns read data, or a write completion, to the requester that was granted. A watchdog bounds memory latency so that a missing acknowledge cannot hang the CPU.

## Interface
Parameters:
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width; the mask width is DATA_W/8
- TIMEOUT, 255, memory wait cycles before forced completion; legal range 1..65535

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- i_req  input  1  fetch request, held until granted
- i_addr  input  ADDR_W  fetch address
- i_gnt  output  1  fetch request accepted this cycle
- i_rvalid  output  1  one-cycle pulse; i_rdata is valid
- i_rdata  output  DATA_W  fetched instruction
- d_req  input  1  data request, held until granted
- d_wen  input  1  1 = write, 0 = read
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  write data
- d_wmask  input  DATA_W/8  byte write enables
- d_gnt  output  1  data request accepted this cycle
- d_rvalid  output  1  one-cycle pulse; read data valid, or write done
- d_rdata  output  DATA_W  load data; 0 for writes
- m_req  output  1  memory request, held until m_ack
- m_wen, m_addr, m_wdata, m_wmask  output  1 / ADDR_W / DATA_W / DATA_W/8  registered copy of the granted request
- m_ack  input  1  memory completes the access this cycle
- m_rdata  input  DATA_W  memory read data, valid with m_ack
- err  output  1  one-cycle pulse alongside the rvalid of a timed-out access

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- Grants are issued only in IDLE or RESP.
  - i_gnt and d_gnt are combinational from the requests and the state.
  - At most one grant is asserted per cycle.
- On a grant:
  - Latch the requester id and the addr/wen/wdata/wmask into the m_* registers.
  - For a fetch, force m_wen=0 and m_wmask=0.
  - Go to BUSY.
- In BUSY, m_req=1.
  - On m_ack: latch m_rdata (or 0 for a write) into the response register, then go to RESP.
  - If the wait counter reaches TIMEOUT: latch 32'hDEADBEEF (zero-extended or truncated to DATA_W), set the error flag, then go to RESP.
- In RESP, pulse rvalid to the owner; assert err if the error flag is set.
  - If a new grant is taken in the same cycle, go to BUSY.
  - Otherwise go to IDLE.
- Priority (fixed): data request wins over fetch, because the load/store belongs to an older instruction.
- The wait counter is 16 bits. It clears on a grant and increments each BUSY cycle without m_ack. m_ack in the cycle the limit is reached takes precedence over the timeout.
- Requests that arrive while BUSY are not granted; the requester holds them.
- Reset asserted mid-transaction:
  - All outputs return to 0 and the state to IDLE immediately.
  - No rvalid pulse is issued for the aborted access.
- Reset values: every output is 0, including m_* registers, response data, i_rdata, d_rdata.

## Timing
- Cycle 0: req high in IDLE, so gnt=1.
- Cycle 1: m_req=1 with the latched fields.
- Cycle k: m_ack. rvalid then pulses at cycle k+1.
- Minimum latency with m_ack at cycle 1 is rvalid at cycle 2, i.e. two cycles from grant.
- Back-to-back: a grant during RESP puts m_req high on the very next cycle. Sustained throughput is one access per two cycles with zero-wait memory.
- i_rdata and d_rdata hold their last value until the next response to the same requester.
- m_* outputs are stable throughout BUSY. m_req drops in the cycle after m_ack.
- Timeout: with no m_ack, rvalid and err pulse together exactly TIMEOUT+2 cycles after the grant.

## Configuration
- ARB_ROUND_ROBIN_EN defined: when both requests are pending in a grant cycle, the requester not served last wins. The last-served bit resets to "fetch", so data wins the first contest. A lone request is always granted.
- ARB_ROUND_ROBIN_EN undefined: fixed data-over-fetch priority as described in Operation.

## Test plan
- Single fetch: i_req, addr 0x80000000; memory acks one cycle after m_req with 0x00000413 -> i_gnt at cycle 0, m_req at cycle 1, i_rvalid with i_rdata=0x00000413 at cycle 3, err=0.
- Store: d_req, d_wen=1, addr 0x80001000, wdata 0x12345678, wmask 0xF, zero-wait ack -> m_wen=1 and fields match at cycle 1; d_rvalid at cycle 2 with d_rdata=0.
- Contention: i_req and d_req high together for 4 transactions -> without the macro, both data transactions are served first; with ARB_ROUND_ROBIN_EN, order is D,I,D,I. Never two grants in one cycle.
- Timeout: TIMEOUT=4, m_ack held low -> d_rvalid and err pulse at cycle 6, d_rdata=0xDEADBEEF, state returns to IDLE.
- Reset mid-BUSY: rst low two cycles after a grant -> m_req=0 and all outputs 0 immediately; no rvalid after release; the next request is served normally.
